// File: rtl/alarm_buzz_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : alarm_buzz_ctrl                                                |
// | Purpose : Alarm time register, MM:SS match on second ticks, and a gated  |
// |           square-wave buzzer driven for a bounded ring period.           |
// | Ports   : clk, rst_n           - clock, async active-low reset           |
// |           i_sec, i_min         - running time from the min/sec counter   |
// |           i_sec_tick           - 1-clk pulse, time already updated       |
// |           i_alarm_en           - alarm armed (level)                     |
// |           i_set_pulse          - enter/exit setup, silences ringing      |
// |           i_pos                - setup field: 0 = seconds, 1 = minutes   |
// |           i_inc_pulse          - increment selected alarm field          |
// |           i_stop_pulse         - silence ringing                         |
// |           o_alarm_sec/min      - alarm time for the display path         |
// |           o_setup, o_ringing   - state indicators                        |
// |           o_buzz               - buzzer drive                            |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module alarm_buzz_ctrl #(
   parameter int CLK_HZ   = 50000000,
   parameter int TONE_HZ  = 1000,
   parameter int RING_SEC = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] i_sec,
   input  logic [5:0] i_min,
   input  logic       i_sec_tick,
   input  logic       i_alarm_en,
   input  logic       i_set_pulse,
   input  logic       i_pos,
   input  logic       i_inc_pulse,
   input  logic       i_stop_pulse,
   output logic [5:0] o_alarm_sec,
   output logic [5:0] o_alarm_min,
   output logic       o_setup,
   output logic       o_ringing,
   output logic       o_buzz
);

   localparam int             c_HALF      = CLK_HZ / (2 * TONE_HZ) - 1;
   localparam int             c_TW        = (c_HALF > 0) ? $clog2(c_HALF + 1) : 1;
   localparam logic [c_TW-1:0] c_HALF_V   = c_TW'(c_HALF);
   localparam logic [5:0]     c_RING_LAST = 6'(RING_SEC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_RING  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic [5:0]        r_alarm_sec;
   logic [5:0]        r_alarm_min;
   logic [c_TW-1:0]   r_tone_cnt;
   logic              r_tone;
   logic [5:0]        r_ring_cnt;

   logic              w_match;
   logic              w_inc_ok;
   logic [5:0]        w_sec_inc;
   logic [5:0]        w_min_inc;

   assign w_match   = (i_min == r_alarm_min) && (i_sec == r_alarm_sec);
   // Set wins over a simultaneous increment.
   assign w_inc_ok  = (r_state == ST_SETUP) && i_inc_pulse && !i_set_pulse;
   assign w_sec_inc = (r_alarm_sec == 6'd59) ? 6'd0 : r_alarm_sec + 6'd1;
   assign w_min_inc = (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_set_pulse)
               w_state_nx = ST_SETUP;
            else if (i_alarm_en && i_sec_tick && w_match)
               w_state_nx = ST_RING;
         end
         ST_SETUP: begin
            if (i_set_pulse)
               w_state_nx = ST_IDLE;
         end
         ST_RING: begin
            // Silencing inputs take priority over the tick that would end the ring.
            if (i_stop_pulse || i_set_pulse || !i_alarm_en)
               w_state_nx = ST_IDLE;
            else if (i_sec_tick && (r_ring_cnt == c_RING_LAST))
               w_state_nx = ST_IDLE;
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_alarm_sec <= 6'd0;
         r_alarm_min <= 6'd0;
         r_tone_cnt  <= '0;
         r_tone      <= 1'b0;
         r_ring_cnt  <= 6'd0;
      end else begin
         r_state <= w_state_nx;

         if (w_inc_ok) begin
            if (i_pos)
               r_alarm_min <= w_min_inc;
            else
               r_alarm_sec <= w_sec_inc;
         end

         // Tone only advances while staying in RING; the entry edge leaves it
         // at zero so the first toggle lands HALF+1 clocks after entry.
         if (w_state_nx != ST_RING) begin
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
         end else if (r_state == ST_RING) begin
            if (r_tone_cnt == c_HALF_V) begin
               r_tone_cnt <= '0;
               r_tone     <= ~r_tone;
            end else begin
               r_tone_cnt <= r_tone_cnt + 1'b1;
            end
         end

         if (r_state != ST_RING && w_state_nx == ST_RING)
            r_ring_cnt <= 6'd0;
         else if (r_state == ST_RING && w_state_nx == ST_RING && i_sec_tick)
            r_ring_cnt <= r_ring_cnt + 6'd1;
      end
   end

   assign o_alarm_sec = r_alarm_sec;
   assign o_alarm_min = r_alarm_min;
   assign o_setup     = (r_state == ST_SETUP);
   assign o_ringing   = (r_state == ST_RING);
   // Beep on even ring seconds, silent on odd ones.
   assign o_buzz      = (r_state == ST_RING) && r_tone && !r_ring_cnt[0];

endmodule
`default_nettype wire

// File: tb/tb_alarm_buzz_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_alarm_buzz_ctrl                                             |
// | Purpose : Scoreboard bench for alarm_buzz_ctrl with a behavioural model. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alarm_buzz_ctrl;

   localparam int CLK_HZ   = 100;
   localparam int TONE_HZ  = 10;
   localparam int RING_SEC = 4;
   localparam int PERIOD   = CLK_HZ / (2 * TONE_HZ);   // clocks per tone half-cycle

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] i_sec, i_min;
   logic       i_sec_tick, i_alarm_en, i_set_pulse, i_pos, i_inc_pulse, i_stop_pulse;
   logic [5:0] o_alarm_sec, o_alarm_min;
   logic       o_setup, o_ringing, o_buzz;

   int total = 0;
   int bad   = 0;

   logic [14:0] sb[$];

   // Behavioural model: mode flags, seconds rung, clocks spent ringing.
   int m_asec, m_amin;
   bit m_setup, m_ring;
   int m_secs, m_cyc;

   always #5 clk = ~clk;

   alarm_buzz_ctrl #(.CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .RING_SEC(RING_SEC)) dut (
      .clk(clk), .rst_n(rst_n), .i_sec(i_sec), .i_min(i_min), .i_sec_tick(i_sec_tick),
      .i_alarm_en(i_alarm_en), .i_set_pulse(i_set_pulse), .i_pos(i_pos),
      .i_inc_pulse(i_inc_pulse), .i_stop_pulse(i_stop_pulse),
      .o_alarm_sec(o_alarm_sec), .o_alarm_min(o_alarm_min), .o_setup(o_setup),
      .o_ringing(o_ringing), .o_buzz(o_buzz)
   );

   function automatic void model_reset();
      m_asec = 0; m_amin = 0; m_setup = 0; m_ring = 0; m_secs = 0; m_cyc = 0;
   endfunction

   function automatic logic [14:0] model_out();
      bit buzz;
      buzz = m_ring && (((m_cyc / PERIOD) % 2) == 1) && ((m_secs % 2) == 0);
      return {6'(m_amin), 6'(m_asec), m_setup, m_ring, buzz};
   endfunction

   function automatic void model_edge();
      if (m_setup) begin
         if (i_set_pulse) m_setup = 0;
         else if (i_inc_pulse) begin
            if (i_pos) m_amin = (m_amin + 1) % 60;
            else       m_asec = (m_asec + 1) % 60;
         end
      end else if (m_ring) begin
         if (i_stop_pulse || i_set_pulse || !i_alarm_en) m_ring = 0;
         else if (i_sec_tick && (m_secs + 1 >= RING_SEC)) m_ring = 0;
         else begin
            if (i_sec_tick) m_secs++;
            m_cyc++;
         end
      end else begin
         if (i_set_pulse) m_setup = 1;
         else if (i_alarm_en && i_sec_tick && int'(i_min) == m_amin && int'(i_sec) == m_asec) begin
            m_ring = 1; m_secs = 0; m_cyc = 0;
         end
      end
   endfunction

   // One clock: model follows the edge, expected response goes to the scoreboard.
   task automatic step();
      @(posedge clk);
      model_edge();
      sb.push_back(model_out());
      @(negedge clk);
      i_set_pulse = 0; i_inc_pulse = 0; i_stop_pulse = 0; i_sec_tick = 0;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic check(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic tick_at(input int mm, input int ss);
      i_min = 6'(mm); i_sec = 6'(ss); i_sec_tick = 1; step();
   endtask

   always @(posedge clk) begin
      logic [14:0] e, g;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         g = {o_alarm_min, o_alarm_sec, o_setup, o_ringing, o_buzz};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL outputs @%0t: got min=%0d sec=%0d setup=%b ring=%b buzz=%b expected min=%0d sec=%0d setup=%b ring=%b buzz=%b",
                     $time, g[14:9], g[8:3], g[2], g[1], g[0], e[14:9], e[8:3], e[2], e[1], e[0]);
         end
      end
   end

   initial begin
      rst_n = 0; i_sec = 0; i_min = 0; i_sec_tick = 0; i_alarm_en = 0;
      i_set_pulse = 0; i_pos = 0; i_inc_pulse = 0; i_stop_pulse = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_ringing", int'(o_ringing), 0);
      check("reset_setup",   int'(o_setup),   0);
      check("reset_buzz",    int'(o_buzz),    0);
      check("reset_alarm",   int'({o_alarm_min, o_alarm_sec}), 0);
      rst_n = 1;
      steps(2);

      // Setup wrap: 61 second increments from 0 lands on 1.
      i_set_pulse = 1; step();
      check("setup_entered", int'(o_setup), 1);
      i_pos = 0;
      for (int k = 0; k < 61; k++) begin i_inc_pulse = 1; step(); end
      i_set_pulse = 1; step();
      check("wrap_sec", int'(o_alarm_sec), 1);
      check("setup_left", int'(o_setup), 0);

      // Program 01:05.
      i_set_pulse = 1; step();
      i_pos = 1; i_inc_pulse = 1; step();
      i_pos = 0;
      for (int k = 0; k < 4; k++) begin i_inc_pulse = 1; step(); end
      i_set_pulse = 1; step();

      // Blocked: disabled, match without tick, match in SETUP.
      i_alarm_en = 0; tick_at(1, 5);
      i_alarm_en = 1; i_min = 1; i_sec = 5; steps(3);
      i_set_pulse = 1; step();
      tick_at(1, 5);
      check("setup_no_ring", int'(o_ringing), 0);
      i_set_pulse = 1; step();

      // Full ring: four ticks ten clocks apart.
      tick_at(1, 5);
      check("ring_started", int'(o_ringing), 1);
      for (int t = 0; t < RING_SEC; t++) begin steps(9); tick_at(1, 5); end
      check("ring_ended", int'(o_ringing), 0);
      steps(3);

      // Stop and tick together: stop wins.
      tick_at(1, 5); steps(12);
      i_stop_pulse = 1; tick_at(1, 6);
      check("stop_priority", int'(o_ringing), 0);
      check("stop_buzz", int'(o_buzz), 0);
      steps(2);

      // Set/inc collision with minutes at 59.
      i_set_pulse = 1; step();
      i_pos = 1;
      for (int k = 0; k < 58; k++) begin i_inc_pulse = 1; step(); end
      i_set_pulse = 1; i_inc_pulse = 1; step();
      check("collision_min", int'(o_alarm_min), 59);
      i_set_pulse = 1; step();
      i_inc_pulse = 1; step();
      check("inc_after_collision", int'(o_alarm_min), 0);
      i_set_pulse = 1; step();

      // Async reset mid-ring, then a 00:00 tick rings.
      tick_at(0, 5); steps(7);
      #2 rst_n = 0;
      #1;
      check("arst_ringing", int'(o_ringing), 0);
      check("arst_buzz",    int'(o_buzz),    0);
      check("arst_setup",   int'(o_setup),   0);
      check("arst_alarm",   int'({o_alarm_min, o_alarm_sec}), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      step();
      tick_at(0, 0);
      check("ring_after_reset", int'(o_ringing), 1);
      steps(20);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         i_sec_tick   = ($urandom_range(0, 5) == 0);
         i_alarm_en   = ($urandom_range(0, 9) != 0);
         i_set_pulse  = ($urandom_range(0, 39) == 0);
         i_inc_pulse  = ($urandom_range(0, 3) == 0);
         i_stop_pulse = ($urandom_range(0, 59) == 0);
         i_pos        = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) begin
            i_min = 6'(m_amin); i_sec = 6'(m_asec);
         end else begin
            i_min = 6'($urandom_range(0, 59)); i_sec = 6'($urandom_range(0, 59));
         end
         step();
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alarm_buzz_ctrl.md
Name: alarm_buzz_ctrl

Overview:
- Downstream consumer of the min/sec counter outputs in the digital clock.
- Holds a user-settable alarm time (MM:SS) and compares it against the running time on every second tick.
- On a match it drives a gated square-wave buzzer for a bounded ring period, until stopped.
- Exports the alarm time so the display path can show it while in setup.

Parameters:
CLK_HZ, 50000000, frequency of clk in Hz
TONE_HZ, 1000, buzzer square-wave frequency in Hz
RING_SEC, 30, maximum ring duration in second ticks (1..63)

Ports:
clk  input  1  system clock (CLK_HZ)
rst_n  input  1  asynchronous active-low reset
i_sec  input  6  current seconds, 0..59, from the min/sec counter
i_min  input  6  current minutes, 0..59
i_sec_tick  input  1  1-clk pulse; i_sec/i_min already hold the new time in that cycle
i_alarm_en  input  1  level; alarm armed when 1
i_set_pulse  input  1  1-clk debounced pulse; enter/exit setup
i_pos  input  1  setup field select: 0 = seconds, 1 = minutes
i_inc_pulse  input  1  1-clk pulse; increment selected alarm field
i_stop_pulse  input  1  1-clk pulse; silence ringing
o_alarm_sec  output  6  alarm seconds, 0..59
o_alarm_min  output  6  alarm minutes, 0..59
o_setup  output  1  1 while in SETUP
o_ringing  output  1  1 while in RING
o_buzz  output  1  buzzer drive

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: state IDLE; o_alarm_sec=0, o_alarm_min=0, o_setup=0, o_ringing=0, o_buzz=0.
  - Internal: tone counter=0, tone=0, ring counter=0.
- Clocking: all state updates on posedge clk. Outputs are registered, or decoded directly from registered state.
- Tone generator:
  - Free-running counter, terminal value HALF = CLK_HZ/(2*TONE_HZ) - 1.
  - On reaching HALF, the counter clears and tone toggles.
  - Runs only in RING; cleared to 0 with tone=0 in every other state.
- FSM states: IDLE, SETUP, RING.
- IDLE:
  - i_set_pulse -> SETUP.
  - Otherwise, if i_alarm_en=1, i_sec_tick=1, i_min==o_alarm_min and i_sec==o_alarm_sec -> RING with ring counter=0.
  - A match without a tick does nothing.
- SETUP (o_setup=1):
  - i_inc_pulse increments the field selected by i_pos; 59 wraps to 0; no carry between fields.
  - i_set_pulse -> IDLE. If set and inc arrive in the same cycle, set wins and no increment is applied.
  - Alarm matches are ignored; no ringing.
- RING (o_ringing=1):
  - Each i_sec_tick increments the ring counter.
  - When a tick arrives with ring counter == RING_SEC-1 -> IDLE.
  - i_stop_pulse, i_set_pulse, or i_alarm_en=0 -> IDLE immediately, next edge. Priority: stop/set/disable over tick.
  - i_set_pulse in RING only silences; it does not enter SETUP.
  - A match during RING does not restart the ring.
- o_buzz = tone AND (ring counter bit0 == 0), i.e. 1 s beep / 1 s silence cadence; 0 outside RING.
- Latency: the RING entry edge is the edge that samples the matching tick; o_ringing=1 from the next cycle; the first tone toggle follows HALF+1 clocks later.
- Alarm time is retained across RING/IDLE; only reset clears it.
- Reset mid-operation (any state): immediate return to the reset values.
- Widths: ring counter 6 bits; all comparisons unsigned 6-bit.

Test Plan:
- Use CLK_HZ=100, TONE_HZ=10 (HALF=4) and RING_SEC=4 for short sims unless noted.
- Setup wrap: set_pulse, pos=0, 61 inc pulses, set_pulse -> o_alarm_sec=1, o_alarm_min=0, o_setup 1 then 0.
- Match and ring: alarm 01:05, en=1, tick with time 01:05 -> o_ringing=1 next cycle; o_buzz toggles every 5 clks during ring counts 0 and 2, stays 0 during 1 and 3; after 4 ticks -> o_ringing=0, o_buzz=0.
- Stop priority: while ringing, stop_pulse and tick in the same cycle -> IDLE next cycle, ring counter not advanced, o_buzz=0.
- No ring when blocked:
  - en=0 with a matching tick -> stays IDLE.
  - In SETUP with a matching tick -> stays SETUP, o_ringing=0.
  - Match without tick -> no change.
- Set/inc collision: in SETUP with pos=1, alarm min=59; inc+set in the same cycle -> IDLE, min stays 59. Next time in SETUP, one inc -> min=0.
- Async reset mid-RING: rst_n low between edges -> o_ringing, o_buzz, o_setup and alarm fields read 0 immediately. After release, a tick at 00:00 with en=1 rings.
